alu_control_fsm: RTL

ALU_CONTROL_FSM -- requirements
Module: alu_control_fsm

---
 rtl/alu_control_fsm.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_control_fsm.sv
// Sequencer for a switch-driven calculator front end: collects operand A, operand B and the
// operation code, launches an external ALU, waits for its result (bounded by TIMEOUT), then shows it.
//
// Ports:
//   clk, rst                       clock; synchronous active-high clear
//   key_next, key_exec, key_chain  one-cycle key pulses (priority next > chain > exec)
//   sw_data, sw_op                 switch inputs for operand entry and operation select
//   alu_result, alu_overflow,      ALU response, sampled only while waiting in S_RUN
//   alu_div_zero, alu_done
//   alu_start                      one-cycle launch strobe (first S_RUN cycle)
//   operand_a, operand_b,          registered operands and operation code to the ALU
//   operation
//   result_reg, result_valid,      captured result and its status
//   error_flag
//   state_code                     current state for display
module alu_control_fsm #(
    parameter int WIDTH   = 4,
    parameter int OPW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_next,
    input  logic             key_exec,
    input  logic             key_chain,
    input  logic [WIDTH-1:0] sw_data,
    input  logic [OPW-1:0]   sw_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_div_zero,
    input  logic             alu_done,
    output logic             alu_start,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [OPW-1:0]   operation,
    output logic [WIDTH-1:0] result_reg,
    output logic             result_valid,
    output logic             error_flag,
    output logic [2:0]       state_code
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_RUN  = 3'd3,
        S_SHOW = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Last wait-counter value before the timeout fires (counter starts at 0
    // in the first S_RUN cycle).
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             alu_err;

    assign alu_err = alu_overflow | alu_div_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        valid_d = valid_q;
        err_d   = err_q;
        start_d = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_A: begin
                a_d = sw_data;
                if (key_next) state_d = S_B;
            end
            S_B: begin
                b_d = sw_data;
                if (key_next) state_d = S_OP;
            end
            S_OP: begin
                op_d = sw_op;
                if (key_exec) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // A done on the final allowed cycle takes precedence over timeout.
                if (alu_done) begin
                    res_d   = alu_result;
                    err_d   = alu_err;
                    valid_d = ~alu_err;
                    state_d = alu_err ? S_ERR : S_SHOW;
                end else if (cnt_q >= CNT_LAST) begin
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SHOW: begin
                if (key_next) begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end else if (key_chain) begin
                    a_d     = res_q;
                    valid_d = 1'b0;
                    state_d = S_B;
                end
            end
            S_ERR: begin
                if (key_next) begin
                    err_d   = 1'b0;
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
    end

    assign alu_start    = start_q;
    assign operand_a    = a_q;
    assign operand_b    = b_q;
    assign operation    = op_q;
    assign result_reg   = res_q;
    assign result_valid = valid_q;
    assign error_flag   = err_q;
    assign state_code   = state_q;

endmodule
